axi_spmem_slave: RTL and testbench
==================================

// Module: axi_spmem_slave
// PURPOSE
//   AXI4 slave that terminates the data-side AXI master (core LSU -> AXI) and drives a single-port
//   word-addressed SRAM. Serialises reads and writes (one transaction in flight), supports FIXED and
//   INCR bursts up to 256 beats, and arbitrates AR vs AW fairly. Sits directly downstream of the
//   core-to-AXI bridge, on the data path to local memory.
// PARAMETERS
//   AXI_ADDR_WIDTH  32  AXI address width
//   AXI_DATA_WIDTH  32  AXI data width; only 32 is supported
//   AXI_ID_WIDTH    6   AXI ID width; AR/AW ID echoed on R/B
//   AXI_USER_WIDTH  6   AXI user width; R/B user driven 0
//   MEM_ADDR_WIDTH  12  SRAM word-address width (memory = 2^MEM_ADDR_WIDTH words)
// PORTS
//   clk_i        in   1               clock; all logic on rising edge
//   rst_ni       in   1               asynchronous active-low reset
//   slave        -    AXI_BUS.Slave   AXI4 slave port (AW, W, B, AR, R channels)
//   mem_req_o    out  1               SRAM access strobe, one access per cycle asserted
//   mem_we_o     out  1               1 = write, 0 = read; valid with mem_req_o
//   mem_addr_o   out  MEM_ADDR_WIDTH  word address = axi_addr[MEM_ADDR_WIDTH+1:2]
//   mem_be_o     out  4               byte enables (= w_strb on writes, 4'hF on reads)
//   mem_wdata_o  out  32              write data (= w_data)
//   mem_rdata_i  in   32              read data; valid cycle after read req, held until next mem_req_o
// BEHAVIOUR
//   Reset: state IDLE, prio = WRITE; aw/ar/w_ready, r_valid, b_valid, mem_req_o, mem_we_o = 0;
//     latched addr/len/id/burst/beat counter = 0. Reset mid-burst abandons transaction, no R/B issued.
//   FSM: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
//   IDLE: aw_ready = aw_valid & (~ar_valid | prio==WRITE); ar_ready = ar_valid & (~aw_valid | prio==READ)
//     (combinational, only in IDLE). On handshake latch id, addr, len, burst; beat counter = 0;
//     prio flips to the other channel. AR hs -> RD_REQ; AW hs -> WR_DATA.
//   RD_REQ: mem_req_o=1, mem_we_o=0, mem_be_o=4'hF -> RD_DATA next cycle.
//   RD_DATA: r_valid=1, r_data=mem_rdata_i, r_id=latched id, r_resp=2'b00, r_last=(beat==len).
//     r_ready=0: hold all R outputs. Hs & ~last: beat++, addr advance -> RD_REQ. Hs & last -> IDLE.
//     Latency: AR hs in cycle N -> mem read N+1 -> r_valid N+2; 2 cycles/beat minimum.
//   WR_DATA: w_ready=1; mem_req_o=w_valid, mem_we_o=1, be/wdata straight from W (same cycle).
//     Each W hs: beat++, addr advance; hs with beat==len -> WR_RESP. Beat counter is authoritative:
//     w_last is ignored (early/late w_last does not change beat count). w_strb=0 still issues req with be=0.
//   WR_RESP: b_valid=1, b_id=latched id, b_resp=2'b00; hold until b_ready -> IDLE.
//   Address advance: FIXED (2'b00) holds; INCR (2'b01), WRAP (2'b10), reserved (2'b11) all add 4,
//     modulo 2^AXI_ADDR_WIDTH. Upper address bits above MEM_ADDR_WIDTH+1 ignored (aliasing).
//   ax_size assumed 3'b010; ax_lock/cache/prot/qos/region/user ignored. All responses OKAY.
//   No new AR/AW accepted until current transaction's last R beat / B handshake completes.
//   Simultaneous ar_valid & aw_valid in IDLE: exactly one accepted per prio; other waits, served next.
// TESTING
//   Single write addr 0x10 data 0xDEADBEEF strb 4'hF, then read 0x10 -> mem write word 4, B OKAY id echoed,
//     R data 0xDEADBEEF, r_last=1, r_valid exactly 2 cycles after AR hs.
//   INCR write len=3 at 0x100 strb 4'h3, then INCR read len=3 -> mem addrs 64..67, be=4'h3; 4 R beats,
//     r_last only on beat 4.
//   FIXED read len=2 at 0x20 with r_ready low 3 cycles per beat -> mem_addr_o stays 8, r_data/r_valid
//     stable during stall, one mem_req_o per beat.
//   ar_valid & aw_valid raised together from reset, held with new requests -> W, R, W, R order.
//   Write len=1 with w_last on beat 1 -> 2 mem writes, B only after beat 2; b_ready held 0 5 cycles ->
//     b_valid held, no AR accepted meanwhile.
//   rst_ni asserted mid-read burst (beat 2 of 4) -> all valids/readies and mem_req_o 0 immediately;
//     after release a fresh AR completes normally.

Source files
------------

// File: rtl/axi_spmem_slave_if.sv
// AXI_BUS: AXI4 bundle shared by masters and slaves.
//   Master modport drives AW/W/AR and the B/R ready signals; Slave modport is the mirror.
//   Widths follow the address/data/id/user parameters.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_spmem_slave.sv
// axi_spmem_slave: AXI4 slave in front of a single-port word-addressed SRAM.
//   One transaction in flight; FIXED holds the address, every other burst type adds 4 per beat.
//   AR and AW are arbitrated by a priority bit that flips after every accepted address.
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   slave                 AXI4 slave port
//   mem_req_o/mem_we_o    SRAM access strobe and write enable
//   mem_addr_o            SRAM word address (axi address bits [MEM_ADDR_WIDTH+1:2])
//   mem_be_o/mem_wdata_o  byte enables and write data (taken straight from W on writes)
//   mem_rdata_i           read data, valid the cycle after a read request and held afterwards
module axi_spmem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  AXI_BUS.Slave                     slave,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

  localparam logic PRIO_WRITE = 1'b1;
  localparam logic PRIO_READ  = 1'b0;

  state_t                    state_reg, state_next;
  logic                      prio_reg, prio_next;
  logic [AXI_ID_WIDTH-1:0]   id_reg, id_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg, addr_next, addr_adv;
  logic [7:0]                len_reg, len_next;
  logic [1:0]                burst_reg, burst_next;
  logic [7:0]                beat_reg, beat_next;
  logic                      last_beat;
  logic                      aw_ready, ar_ready, w_ready, r_valid, r_last, b_valid;

  // Only FIXED holds; WRAP and the reserved encoding are treated as INCR.
  assign addr_adv  = (burst_reg == 2'b00) ? addr_reg : addr_reg + AXI_ADDR_WIDTH'(4);
  assign last_beat = (beat_reg == len_reg);

  always_comb begin
    state_next  = state_reg;
    prio_next   = prio_reg;
    id_next     = id_reg;
    addr_next   = addr_reg;
    len_next    = len_reg;
    burst_next  = burst_reg;
    beat_next   = beat_reg;
    aw_ready    = 1'b0;
    ar_ready    = 1'b0;
    w_ready     = 1'b0;
    r_valid     = 1'b0;
    r_last      = 1'b0;
    b_valid     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    case (state_reg)
      IDLE: begin
        // Readies are masked while reset is held so nothing looks accepted during reset.
        aw_ready = rst_ni & slave.aw_valid & (~slave.ar_valid | (prio_reg == PRIO_WRITE));
        ar_ready = rst_ni & slave.ar_valid & (~slave.aw_valid | (prio_reg == PRIO_READ));
        if (aw_ready) begin
          id_next    = slave.aw_id;
          addr_next  = slave.aw_addr;
          len_next   = slave.aw_len;
          burst_next = slave.aw_burst;
          beat_next  = 8'd0;
          prio_next  = PRIO_READ;
          state_next = WR_DATA;
        end else if (ar_ready) begin
          id_next    = slave.ar_id;
          addr_next  = slave.ar_addr;
          len_next   = slave.ar_len;
          burst_next = slave.ar_burst;
          beat_next  = 8'd0;
          prio_next  = PRIO_WRITE;
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        state_next = RD_DATA;
      end
      RD_DATA: begin
        // SRAM holds its output until the next request, so a stalled beat stays stable.
        r_valid = 1'b1;
        r_last  = last_beat;
        if (slave.r_ready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            beat_next  = beat_reg + 8'd1;
            addr_next  = addr_adv;
            state_next = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        // The beat counter ends the burst; w_last is deliberately ignored.
        w_ready     = 1'b1;
        mem_req_o   = slave.w_valid;
        mem_we_o    = 1'b1;
        mem_be_o    = slave.w_strb;
        mem_wdata_o = slave.w_data;
        if (slave.w_valid) begin
          beat_next = beat_reg + 8'd1;
          addr_next = addr_adv;
          if (last_beat) state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (slave.b_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      prio_reg  <= PRIO_WRITE;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      burst_reg <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      id_reg    <= id_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      burst_reg <= burst_next;
      beat_reg  <= beat_next;
    end
  end

  assign mem_addr_o     = addr_reg[MEM_ADDR_WIDTH+1:2];

  assign slave.aw_ready = aw_ready;
  assign slave.ar_ready = ar_ready;
  assign slave.w_ready  = w_ready;
  assign slave.r_valid  = r_valid;
  assign slave.r_last   = r_last;
  assign slave.r_data   = mem_rdata_i;
  assign slave.r_id     = id_reg;
  assign slave.r_resp   = 2'b00;
  assign slave.r_user   = '0;
  assign slave.b_valid  = b_valid;
  assign slave.b_id     = id_reg;
  assign slave.b_resp   = 2'b00;
  assign slave.b_user   = '0;

  // Sideband fields the slave does not interpret.
  logic unused_sig;
  assign unused_sig = ^{slave.aw_size, slave.aw_lock, slave.aw_cache, slave.aw_prot,
                        slave.aw_qos, slave.aw_region, slave.aw_user,
                        slave.ar_size, slave.ar_lock, slave.ar_cache, slave.ar_prot,
                        slave.ar_qos, slave.ar_region, slave.ar_user,
                        slave.w_last, slave.w_user, addr_reg};
endmodule

// File: tb/tb_axi_spmem_slave.sv
module tb_axi_spmem_slave;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        mem_req_o, mem_we_o;
  logic [11:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) axi ();

  axi_spmem_slave #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6),
    .MEM_ADDR_WIDTH(12)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .slave(axi),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- external SRAM device ----------------
  logic [31:0] sram [0:4095];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (mem_be_o[k]) sram[mem_addr_o][8*k +: 8] <= mem_wdata_o[8*k +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic we; logic [11:0] addr; logic [3:0] be; logic [31:0] wdata; } acc_t;
  typedef struct { logic [31:0] data; logic [5:0] id; logic last; } rbeat_t;

  logic [31:0] ref_mem [0:4095];
  acc_t        acc_q[$];
  rbeat_t      r_q[$];
  logic [5:0]  b_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] base, input int b);
    return base + 32'(b) * 32'h01010101;
  endfunction

  task automatic model_write(input logic [5:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [3:0] strb,
                             input logic [31:0] base);
    logic [31:0] a;
    logic [31:0] d;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      d = beat_data(base, b);
      acc_q.push_back('{we: 1'b1, addr: a[13:2], be: strb, wdata: d});
      for (int k = 0; k < 4; k++)
        if (strb[k]) ref_mem[a[13:2]][8*k +: 8] = d[8*k +: 8];
      if (burst != 2'b00) a = a + 32'd4;
    end
    b_q.push_back(id);
  endtask

  task automatic model_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
    logic [31:0] a;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      acc_q.push_back('{we: 1'b0, addr: a[13:2], be: 4'hF, wdata: 32'h0});
      r_q.push_back('{data: ref_mem[a[13:2]], id: id, last: (b == len)});
      if (burst != 2'b00) a = a + 32'd4;
    end
  endtask

  // ---------------- compare process ----------------
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  acc_t        cur_acc;
  rbeat_t      cur_r;
  logic [5:0]  cur_b;
  int          req_cnt = 0, wr_cnt = 0, r_hs_cnt = 0, r_last_cnt = 0;
  int          last_wr_cyc = 0, last_ar_cyc = 0, r_rise_cyc = 0, b_rise_cyc = 0;
  logic [11:0] last_wr_addr;
  logic [31:0] last_r_data;
  logic        last_r_last;
  logic [11:0] wr_log[$];
  logic [7:0]  hs_order[$];
  logic        prev_stall = 1'b0, prev_rv = 1'b0, prev_bv = 1'b0;
  logic [40:0] prev_r;

  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
      prev_rv    = 1'b0;
      prev_bv    = 1'b0;
    end else begin
      if (axi.aw_valid && axi.aw_ready) hs_order.push_back("W");
      if (axi.ar_valid && axi.ar_ready) begin
        hs_order.push_back("R");
        last_ar_cyc = cyc;
      end
      if (mem_req_o) begin
        req_cnt++;
        if (acc_q.size() == 0) begin
          check("mem_unexpected_req", mem_req_o, 1'b0);
        end else begin
          cur_acc = acc_q.pop_front();
          check("mem_we", mem_we_o, cur_acc.we);
          check("mem_addr", mem_addr_o, cur_acc.addr);
          check("mem_be", mem_be_o, cur_acc.be);
          if (cur_acc.we) check("mem_wdata", mem_wdata_o, cur_acc.wdata);
        end
        if (mem_we_o) begin
          wr_cnt++;
          last_wr_addr = mem_addr_o;
          last_wr_cyc  = cyc;
          wr_log.push_back(mem_addr_o);
        end
      end
      if (prev_stall)
        check("r_hold", {axi.r_valid, axi.r_last, axi.r_id, axi.r_data}, prev_r);
      if (axi.r_valid && !prev_rv) r_rise_cyc = cyc;
      if (axi.r_valid && axi.r_ready) begin
        r_hs_cnt++;
        if (axi.r_last) r_last_cnt++;
        last_r_data = axi.r_data;
        last_r_last = axi.r_last;
        if (r_q.size() == 0) begin
          check("r_unexpected", axi.r_valid, 1'b0);
        end else begin
          cur_r = r_q.pop_front();
          check("r_data", axi.r_data, cur_r.data);
          check("r_id", axi.r_id, cur_r.id);
          check("r_last", axi.r_last, cur_r.last);
          check("r_resp", axi.r_resp, 2'b00);
        end
      end
      prev_stall = axi.r_valid && !axi.r_ready;
      prev_r     = {axi.r_valid, axi.r_last, axi.r_id, axi.r_data};
      prev_rv    = axi.r_valid;
      if (axi.b_valid && !prev_bv) b_rise_cyc = cyc;
      prev_bv = axi.b_valid;
      if (axi.b_valid && axi.b_ready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected", axi.b_valid, 1'b0);
        end else begin
          cur_b = b_q.pop_front();
          check("b_id", axi.b_id, cur_b);
          check("b_resp", axi.b_resp, 2'b00);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_aw(input logic [5:0] id, input logic [31:0] addr, input int len,
                        input logic [1:0] burst);
    axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = 8'(len); axi.aw_burst = burst;
    axi.aw_valid = 1'b1;
  endtask

  task automatic set_ar(input logic [5:0] id, input logic [31:0] addr, input int len,
                        input logic [1:0] burst);
    axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = 8'(len); axi.ar_burst = burst;
    axi.ar_valid = 1'b1;
  endtask

  task automatic wait_aw_hs();
    logic to;
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (axi.aw_ready) begin to = 1'b0; break; end
    end
    check("aw_timeout", to, 1'b0);
    @(posedge clk); #1;
    axi.aw_valid = 1'b0;
  endtask

  task automatic wait_ar_hs();
    logic to;
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (axi.ar_ready) begin to = 1'b0; break; end
    end
    check("ar_timeout", to, 1'b0);
    @(posedge clk); #1;
    axi.ar_valid = 1'b0;
  endtask

  task automatic do_w(input int len, input logic [31:0] base, input logic [3:0] strb,
                      input int wlast_beat);
    logic to;
    for (int b = 0; b <= len; b++) begin
      axi.w_data  = beat_data(base, b);
      axi.w_strb  = strb;
      axi.w_last  = (b == wlast_beat);
      axi.w_valid = 1'b1;
      to = 1'b1;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (axi.w_ready) begin to = 1'b0; break; end
      end
      check("w_timeout", to, 1'b0);
      @(posedge clk); #1;
    end
    axi.w_valid = 1'b0;
    axi.w_last  = 1'b0;
  endtask

  task automatic wait_b();
    logic to;
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (axi.b_valid && axi.b_ready) begin to = 1'b0; break; end
    end
    check("b_timeout", to, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_r_last();
    logic to;
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (axi.r_valid && axi.r_ready && axi.r_last) begin to = 1'b0; break; end
    end
    check("r_last_timeout", to, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  function automatic logic [6:0] ctl_vec();
    return {axi.aw_ready, axi.ar_ready, axi.w_ready, axi.r_valid, axi.b_valid,
            mem_req_o, mem_we_o};
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] arb_addr [2];
  logic [31:0] arb_data [2];
  int          s_req, s_r, s_rl, s_wr, aw_i, ar_i, w_i;
  logic        aw_h, ar_h, w_h;
  logic [31:0] order_word;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i]    = {20'hC0FFE, i[11:0]};
      ref_mem[i] = {20'hC0FFE, i[11:0]};
    end
    mem_rdata_i = 32'h0;
    axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = 3'b010; axi.aw_burst = 2'b01;
    axi.aw_lock = 1'b0; axi.aw_cache = '0; axi.aw_prot = '0; axi.aw_qos = '0; axi.aw_region = '0;
    axi.aw_user = '0; axi.aw_valid = 1'b0;
    axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = 3'b010; axi.ar_burst = 2'b01;
    axi.ar_lock = 1'b0; axi.ar_cache = '0; axi.ar_prot = '0; axi.ar_qos = '0; axi.ar_region = '0;
    axi.ar_user = '0; axi.ar_valid = 1'b0;
    axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0; axi.w_user = '0; axi.w_valid = 1'b0;
    axi.b_ready = 1'b1; axi.r_ready = 1'b1;

    // Reset state, with both address channels requesting.
    rst_ni = 1'b0;
    axi.aw_valid = 1'b1; axi.ar_valid = 1'b1;
    @(negedge clk);
    check("reset_outputs", ctl_vec(), 7'd0);
    @(posedge clk); #1;
    axi.aw_valid = 1'b0; axi.ar_valid = 1'b0;
    rst_ni = 1'b1;

    // 1: single write then read back at 0x10.
    model_write(6'd5, 32'h10, 0, 2'b01, 4'hF, 32'hDEADBEEF);
    set_aw(6'd5, 32'h10, 0, 2'b01);
    fork
      wait_aw_hs();
      do_w(0, 32'hDEADBEEF, 4'hF, 0);
    join
    wait_b();
    check("t1_wr_word", last_wr_addr, 12'd4);
    model_read(6'd9, 32'h10, 0, 2'b01);
    set_ar(6'd9, 32'h10, 0, 2'b01);
    wait_ar_hs();
    wait_r_last();
    check("t1_rdata", last_r_data, 32'hDEADBEEF);
    check("t1_rlast", last_r_last, 1'b1);
    check("t1_latency", r_rise_cyc - last_ar_cyc, 2);

    // 2: INCR len=3 write (strb 3) then read back.
    wr_log.delete();
    model_write(6'd1, 32'h100, 3, 2'b01, 4'h3, 32'h11223344);
    set_aw(6'd1, 32'h100, 3, 2'b01);
    fork
      wait_aw_hs();
      do_w(3, 32'h11223344, 4'h3, 3);
    join
    wait_b();
    check("t2_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_wr_addr", wr_log[i], 12'd64 + 12'(i));
    s_r = r_hs_cnt; s_rl = r_last_cnt;
    model_read(6'd2, 32'h100, 3, 2'b01);
    set_ar(6'd2, 32'h100, 3, 2'b01);
    wait_ar_hs();
    wait_r_last();
    check("t2_r_beats", r_hs_cnt - s_r, 4);
    check("t2_r_lasts", r_last_cnt - s_rl, 1);
    check("t2_beat0_lo", ref_mem[64], {20'hC0FFE, 12'h040} & 32'hFFFF0000 | 32'h00003344);

    // 3: FIXED len=2 read at 0x20 with 3 stall cycles per beat.
    s_req = req_cnt; s_r = r_hs_cnt;
    axi.r_ready = 1'b0;
    model_read(6'd3, 32'h20, 2, 2'b00);
    set_ar(6'd3, 32'h20, 2, 2'b00);
    wait_ar_hs();
    for (int b = 0; b < 3; b++) begin
      aw_h = 1'b1;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (axi.r_valid) begin aw_h = 1'b0; break; end
      end
      check("t3_rvalid_timeout", aw_h, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      axi.r_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      axi.r_ready = 1'b0;
    end
    axi.r_ready = 1'b1;
    check("t3_req_count", req_cnt - s_req, 3);
    check("t3_r_beats", r_hs_cnt - s_r, 3);

    // 4: AR and AW together from reset -> W, R, W, R.
    arb_addr[0] = 32'h200; arb_addr[1] = 32'h204;
    arb_data[0] = 32'hCAFE0001; arb_data[1] = 32'hCAFE0002;
    model_write(6'd10, arb_addr[0], 0, 2'b01, 4'hF, arb_data[0]);
    model_read(6'd11, arb_addr[0], 0, 2'b01);
    model_write(6'd12, arb_addr[1], 0, 2'b01, 4'hF, arb_data[1]);
    model_read(6'd13, arb_addr[1], 0, 2'b01);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    hs_order.delete();
    aw_i = 0; ar_i = 0; w_i = 0;
    set_aw(6'd10, arb_addr[0], 0, 2'b01);
    set_ar(6'd11, arb_addr[0], 0, 2'b01);
    axi.w_data = arb_data[0]; axi.w_strb = 4'hF; axi.w_last = 1'b1; axi.w_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int c = 0; c < 300 && (axi.aw_valid || axi.ar_valid || axi.w_valid); c++) begin
      @(negedge clk);
      aw_h = axi.aw_valid & axi.aw_ready;
      ar_h = axi.ar_valid & axi.ar_ready;
      w_h  = axi.w_valid & axi.w_ready;
      @(posedge clk); #1;
      if (aw_h) begin
        aw_i++;
        if (aw_i < 2) set_aw(6'd12, arb_addr[1], 0, 2'b01); else axi.aw_valid = 1'b0;
      end
      if (ar_h) begin
        ar_i++;
        if (ar_i < 2) set_ar(6'd13, arb_addr[1], 0, 2'b01); else axi.ar_valid = 1'b0;
      end
      if (w_h) begin
        w_i++;
        if (w_i < 2) axi.w_data = arb_data[1]; else begin axi.w_valid = 1'b0; axi.w_last = 1'b0; end
      end
    end
    wait_r_last();
    repeat (2) @(posedge clk); #1;
    order_word = 32'h0;
    for (int i = 0; i < hs_order.size() && i < 4; i++) order_word = {order_word[23:0], hs_order[i]};
    check("t4_order", order_word, "WRWR");
    check("t4_hs_count", hs_order.size(), 4);

    // 5: write len=1 with w_last on the first beat; B held off for 5 cycles.
    s_wr = wr_cnt;
    axi.b_ready = 1'b0;
    model_write(6'd20, 32'h300, 1, 2'b01, 4'hF, 32'h0BADF00D);
    set_aw(6'd20, 32'h300, 1, 2'b01);
    fork
      wait_aw_hs();
      do_w(1, 32'h0BADF00D, 4'hF, 0);
    join
    check("t5_wr_count", wr_cnt - s_wr, 2);
    model_read(6'd21, 32'h300, 1, 2'b01);
    set_ar(6'd21, 32'h300, 1, 2'b01);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_b_held", axi.b_valid, 1'b1);
      check("t5_ar_blocked", axi.ar_ready, 1'b0);
    end
    check("t5_b_after_last", b_rise_cyc - last_wr_cyc, 1);
    @(posedge clk); #1;
    axi.b_ready = 1'b1;
    wait_b();
    wait_ar_hs();
    wait_r_last();

    // 6: reset in the middle of a 4-beat read, then a fresh read.
    model_read(6'd30, 32'h100, 3, 2'b01);
    set_ar(6'd30, 32'h100, 3, 2'b01);
    wait_ar_hs();
    s_r = r_hs_cnt;
    aw_h = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (axi.r_valid && r_hs_cnt - s_r == 1) begin aw_h = 1'b0; break; end
    end
    check("t6_beat2_timeout", aw_h, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    check("t6_reset_outputs", ctl_vec(), 7'd0);
    acc_q.delete(); r_q.delete(); b_q.delete();
    @(posedge clk); @(posedge clk);
    #1 rst_ni = 1'b1;
    model_read(6'd31, 32'h10, 0, 2'b01);
    set_ar(6'd31, 32'h10, 0, 2'b01);
    wait_ar_hs();
    wait_r_last();
    check("t6_fresh_rdata", last_r_data, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    check("end_acc_q_empty", acc_q.size(), 0);
    check("end_r_q_empty", r_q.size(), 0);
    check("end_b_q_empty", b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
